norm_check_stream: RTL and testbench

Sequential, parametrised successor to the combinational coefficient norm check. It consumes a stream of LANES coefficients per beat over a vector of 1–8 polynomials of NUM_COEFF coefficients each, using a valid/ready handshake. It accumulates a sticky reject flag and records the first rejecting position. It sits between the signing datapath (z, r0, ct0 producers) and the signing controller, which uses done/rej to decide whether to restart with a new nonce.

---
 rtl/dilithium_pkg.sv | 35 +++
 rtl/norm_check_stream_if.sv | 18 +
 rtl/norm_bound_sel.sv | 42 ++++
 rtl/norm_check_stream.sv | 222 ++++++++++++++++++++++
 tb/tb_norm_check_stream.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dilithium_pkg
//  Description : Shared Dilithium constants, norm-check mode encodings and
//                the norm-check controller state type.
//  Revision    : 1.0
// ============================================================================
package dilithium_pkg;

    localparam int unsigned Q            = 32'd8380417;
    localparam int unsigned GAMMA1_LVL2  = 32'd131072;
    localparam int unsigned GAMMA1_LVL35 = 32'd524288;
    localparam int unsigned GAMMA2_LVL2  = 32'd95232;
    localparam int unsigned GAMMA2_LVL35 = 32'd261888;
    localparam int unsigned BETA_LVL2    = 32'd78;
    localparam int unsigned BETA_LVL3    = 32'd196;
    localparam int unsigned BETA_LVL5    = 32'd120;

    // Encoding 3 is treated as G2 by the bound selector.
    typedef enum logic [1:0] {
        G2_SUB_BETA = 2'd0,
        G1_SUB_BETA = 2'd1,
        G2          = 2'd2
    } norm_mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } chk_state_e;

endpackage
`default_nettype wire

// File: rtl/norm_check_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : norm_check_stream_if
//  Description : Valid/ready coefficient beat stream into the norm checker.
//  Revision    : 1.0
// ============================================================================
interface norm_check_stream_if #(
    parameter int LANES  = 4,
    parameter int COEF_W = 24
);
    logic                    validi;
    logic [LANES*COEF_W-1:0] di;
    logic                    readyi;

    modport master (output validi, output di, input readyi);
    modport slave  (input validi, input di, output readyi);
endinterface
`default_nettype wire

// File: rtl/norm_bound_sel.sv
`default_nettype none
// ============================================================================
//  Module      : norm_bound_sel
//  Description : Combinational reject-band bounds from security level and mode.
//  Revision    : 1.0
// ============================================================================
module norm_bound_sel
    import dilithium_pkg::*;
#(
    parameter int COEF_W = 24
) (
    input  wire logic [2:0]        i_sec_lvl,
    input  wire logic [1:0]        i_mode,
    output logic      [COEF_W-1:0] o_upper,
    output logic      [COEF_W-1:0] o_lower
);

    logic [31:0] w_gamma1;
    logic [31:0] w_gamma2;
    logic [31:0] w_beta;
    logic [31:0] w_bound;

    always_comb begin
        w_gamma1 = (i_sec_lvl == 3'd2) ? GAMMA1_LVL2 : GAMMA1_LVL35;
        w_gamma2 = (i_sec_lvl == 3'd2) ? GAMMA2_LVL2 : GAMMA2_LVL35;
        case (i_sec_lvl)
            3'd2:    w_beta = BETA_LVL2;
            3'd3:    w_beta = BETA_LVL3;
            default: w_beta = BETA_LVL5;
        endcase
        case (i_mode)
            G2_SUB_BETA: w_bound = w_gamma2 - w_beta;
            G1_SUB_BETA: w_bound = w_gamma1 - w_beta;
            default:     w_bound = w_gamma2;
        endcase
    end

    assign o_upper = COEF_W'(w_bound);
    assign o_lower = COEF_W'(Q - w_bound);

endmodule
`default_nettype wire

// File: rtl/norm_check_stream.sv
`default_nettype none
// ============================================================================
//  Module      : norm_check_stream
//  Description : Streaming coefficient norm check with sticky reject flag and
//                first-reject position capture.
//  Revision    : 1.0
// ============================================================================
module norm_check_stream
    import dilithium_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int COEF_W    = 24,
    parameter int NUM_COEFF = 256
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst,
    input  wire logic                                 start,
    input  wire logic [2:0]                           sec_lvl,
    input  wire logic [1:0]                           mode,
    input  wire logic [3:0]                           npoly,
    norm_check_stream_if.slave                        s,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      rej,
    output logic      [2:0]                           rej_poly,
    output logic      [$clog2(NUM_COEFF/LANES)-1:0]   rej_beat,
    output logic      [LANES-1:0]                     rej_mask
);

    localparam int BEATS  = NUM_COEFF / LANES;
    localparam int BEAT_W = $clog2(BEATS);

    chk_state_e          r_state;
    chk_state_e          w_state_nxt;
    logic                w_ready;
    logic                w_busy;
    logic                w_done;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_last_poly;

    logic [2:0]          r_sec_lvl;
    logic [1:0]          r_mode;
    logic [2:0]          r_last_poly;
    logic [2:0]          w_last_poly_in;

    logic [COEF_W-1:0]   w_upper;
    logic [COEF_W-1:0]   w_lower;
    logic [COEF_W-1:0]   r_upper;
    logic [COEF_W-1:0]   r_lower;

    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [2:0]          r_poly_cnt;
    logic [LANES-1:0]    w_lane_rej;

    logic                r_stg_vld;
    logic [LANES-1:0]    r_stg_mask;
    logic [2:0]          r_stg_poly;
    logic [BEAT_W-1:0]   r_stg_beat;

    logic                r_rej;
    logic [2:0]          r_rej_poly;
    logic [BEAT_W-1:0]   r_rej_beat;
    logic [LANES-1:0]    r_rej_mask;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));
    assign w_last_poly = (r_poly_cnt == r_last_poly);

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_ready = 1'b1;
                if (s.validi && w_last_beat && w_last_poly) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = s.validi && w_ready;
    assign s.readyi = w_ready;
    assign busy     = w_busy;
    assign done     = w_done;

    // ------------------------------------------------------------------
    // Configuration latch; npoly 0 means one poly, above 8 saturates
    // ------------------------------------------------------------------
    always_comb begin
        if (npoly == 4'd0) begin
            w_last_poly_in = 3'd0;
        end else if (npoly > 4'd8) begin
            w_last_poly_in = 3'd7;
        end else begin
            w_last_poly_in = 3'(npoly - 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_lvl   <= 3'd0;
            r_mode      <= 2'd0;
            r_last_poly <= 3'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_sec_lvl   <= sec_lvl;
            r_mode      <= mode;
            r_last_poly <= w_last_poly_in;
        end
    end

    norm_bound_sel #(
        .COEF_W (COEF_W)
    ) u_bound_sel (
        .i_sec_lvl (r_sec_lvl),
        .i_mode    (r_mode),
        .o_upper   (w_upper),
        .o_lower   (w_lower)
    );

    // ------------------------------------------------------------------
    // Bounds and beat/poly position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upper    <= '0;
            r_lower    <= '0;
            r_beat_cnt <= '0;
            r_poly_cnt <= 3'd0;
        end else if (r_state == S_LOAD) begin
            r_upper    <= w_upper;
            r_lower    <= w_lower;
            r_beat_cnt <= '0;
            r_poly_cnt <= 3'd0;
        end else if (w_accept) begin
            r_beat_cnt <= w_last_beat ? '0 : (r_beat_cnt + BEAT_W'(1));
            if (w_last_beat) begin
                r_poly_cnt <= r_poly_cnt + 3'd1;
            end
        end
    end

    // Inclusive band test at full lane width
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [COEF_W-1:0] w_coef;
        assign w_coef         = s.di[gi*COEF_W +: COEF_W];
        assign w_lane_rej[gi] = (w_coef >= r_upper) && (w_coef <= r_lower);
    end

    // ------------------------------------------------------------------
    // Compare stage register and sticky accumulate
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_LOAD)) begin
            r_stg_vld  <= 1'b0;
            r_stg_mask <= '0;
            r_stg_poly <= 3'd0;
            r_stg_beat <= '0;
        end else begin
            r_stg_vld  <= w_accept;
            r_stg_mask <= w_lane_rej;
            r_stg_poly <= r_poly_cnt;
            r_stg_beat <= r_beat_cnt;
        end
    end

    // Position fields are captured only while rej is still clear
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_LOAD)) begin
            r_rej      <= 1'b0;
            r_rej_poly <= 3'd0;
            r_rej_beat <= '0;
            r_rej_mask <= '0;
        end else if (r_stg_vld && (|r_stg_mask)) begin
            r_rej <= 1'b1;
            if (!r_rej) begin
                r_rej_poly <= r_stg_poly;
                r_rej_beat <= r_stg_beat;
                r_rej_mask <= r_stg_mask;
            end
        end
    end

    assign rej      = r_rej;
    assign rej_poly = r_rej_poly;
    assign rej_beat = r_rej_beat;
    assign rej_mask = r_rej_mask;

endmodule
`default_nettype wire

// File: tb/tb_norm_check_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_norm_check_stream
//  Description : Directed and randomized self-checking bench for norm_check_stream.
//  Revision    : 1.0
// ============================================================================
module tb_norm_check_stream;

    localparam int LANES     = 4;
    localparam int COEF_W    = 24;
    localparam int NUM_COEFF = 256;
    localparam int BEATS     = NUM_COEFF / LANES;
    localparam int QV        = 8380417;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sec_lvl;
    logic [1:0] mode;
    logic [3:0] npoly;
    logic       busy;
    logic       done;
    logic       rej;
    logic [2:0] rej_poly;
    logic [5:0] rej_beat;
    logic [3:0] rej_mask;

    int errors = 0;
    int checks = 0;

    logic [LANES*COEF_W-1:0] stim [0:511];

    norm_check_stream_if #(.LANES(LANES), .COEF_W(COEF_W)) s_if ();

    norm_check_stream #(
        .LANES     (LANES),
        .COEF_W    (COEF_W),
        .NUM_COEFF (NUM_COEFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sec_lvl  (sec_lvl),
        .mode     (mode),
        .npoly    (npoly),
        .s        (s_if),
        .busy     (busy),
        .done     (done),
        .rej      (rej),
        .rej_poly (rej_poly),
        .rej_beat (rej_beat),
        .rej_mask (rej_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reject band straight from the published parameter tables
    function automatic void ref_bounds(input int lvl, input int md, output int upper, output int lower);
        int g1, g2, beta, b;
        g1   = (lvl == 2) ? 131072 : 524288;
        g2   = (lvl == 2) ? 95232 : 261888;
        beta = (lvl == 2) ? 78 : ((lvl == 3) ? 196 : 120);
        if (md == 0)      b = g2 - beta;
        else if (md == 1) b = g1 - beta;
        else              b = g2;
        upper = b;
        lower = QV - b;
    endfunction

    function automatic logic [COEF_W-1:0] pick_safe(input int upper, input int lower);
        if ($urandom_range(0, 1) == 0) return COEF_W'($urandom_range(upper - 1, 0));
        return COEF_W'($urandom_range(32'hFFFFFF, lower + 1));
    endfunction

    function automatic logic [COEF_W-1:0] pick_band(input int upper, input int lower);
        return COEF_W'($urandom_range(lower, upper));
    endfunction

    function automatic logic [LANES*COEF_W-1:0] junk_beat(input int upper, input int lower);
        logic [LANES*COEF_W-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*COEF_W +: COEF_W] = pick_band(upper, lower);
        return v;
    endfunction

    task automatic build_safe(input int upper, input int lower, input int n, input int rej_per_64);
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < LANES; l++) stim[i][l*COEF_W +: COEF_W] = pick_safe(upper, lower);
            if ($urandom_range(63, 0) < rej_per_64)
                stim[i][$urandom_range(LANES-1, 0)*COEF_W +: COEF_W] = pick_band(upper, lower);
        end
    endtask

    function automatic int rand_lvl();
        int k;
        k = $urandom_range(2, 0);
        return (k == 0) ? 2 : ((k == 1) ? 3 : 5);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ready"}, 32'(s_if.readyi), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rej"}, 32'(rej), 0);
        chk({tag, "_rej_poly"}, 32'(rej_poly), 0);
        chk({tag, "_rej_beat"}, 32'(rej_beat), 0);
        chk({tag, "_rej_mask"}, 32'(rej_mask), 0);
    endtask

    // One check from start to the cycle after done (or a reset at abort_at beats)
    task automatic run_check(input string tag, input int lvl, input int md, input int np,
                             input int gap_pct, input int abort_at, input bit poke);
        int upper, lower, eff_np, nbeats, target, idx, cyc, c;
        bit e_rej, v, poked;
        int e_p, e_b;
        logic [LANES-1:0] e_m, m;

        ref_bounds(lvl, md, upper, lower);
        eff_np = (np == 0) ? 1 : ((np > 8) ? 8 : np);
        nbeats = eff_np * BEATS;

        e_rej = 1'b0; e_p = 0; e_b = 0; e_m = '0;
        for (int i = 0; i < nbeats; i++) begin
            m = '0;
            for (int l = 0; l < LANES; l++) begin
                c    = int'(stim[i][l*COEF_W +: COEF_W]);
                m[l] = (c >= upper) && (c <= lower);
            end
            if (!e_rej && (m != '0)) begin
                e_rej = 1'b1; e_p = i / BEATS; e_b = i % BEATS; e_m = m;
            end
        end

        // Start, offering in-band junk that must not be consumed before RUN
        @(negedge clk);
        start = 1'b1; sec_lvl = 3'(lvl); mode = 2'(md); npoly = 4'(np);
        s_if.validi = 1'b1; s_if.di = junk_beat(upper, lower);
        @(negedge clk);
        start = 1'b0; sec_lvl = 3'd2; mode = 2'd1; npoly = 4'd1;
        chk({tag, "_busy_load"}, 32'(busy), 1);
        chk({tag, "_ready_load"}, 32'(s_if.readyi), 0);
        @(negedge clk);

        target = (abort_at >= 0) ? abort_at : nbeats;
        idx = 0; cyc = 0; poked = 1'b0;
        while (idx < target && cyc < 6 * nbeats + 50) begin
            chk({tag, "_ready_run"}, 32'(s_if.readyi), 1);
            if (poke && !poked && idx == nbeats / 2) begin
                start = 1'b1; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            v = ($urandom_range(99, 0) >= gap_pct);
            s_if.validi = v;
            s_if.di     = v ? stim[idx] : junk_beat(upper, lower);
            if (v && s_if.readyi) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_accepted"}, 32'(idx), 32'(target));
        if (idx != target || abort_at >= 0) begin
            s_if.validi = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_vals({tag, "_abort"});
            return;
        end

        // u+1: drain; junk still offered
        s_if.di = junk_beat(upper, lower);
        chk({tag, "_ready_drain"}, 32'(s_if.readyi), 0);
        chk({tag, "_busy_drain"}, 32'(busy), 1);
        chk({tag, "_done_early"}, 32'(done), 0);
        @(negedge clk);
        // u+2: done
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_rej"}, 32'(rej), 32'(e_rej));
        chk({tag, "_rej_poly"}, 32'(rej_poly), 32'(e_p));
        chk({tag, "_rej_beat"}, 32'(rej_beat), 32'(e_b));
        chk({tag, "_rej_mask"}, 32'(rej_mask), 32'(e_m));
        if (poke) begin
            start = 1'b1; sec_lvl = 3'd2; mode = 2'd1; npoly = 4'd1;
        end
        @(negedge clk);
        // u+3: idle, results held
        start = 1'b0;
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_after"}, 32'(done), 0);
        chk({tag, "_rej_held"}, 32'(rej), 32'(e_rej));
        chk({tag, "_mask_held"}, 32'(rej_mask), 32'(e_m));
        if (poke) begin
            repeat (3) begin
                @(negedge clk);
                chk({tag, "_no_restart_busy"}, 32'(busy), 0);
                chk({tag, "_no_extra_done"}, 32'(done), 0);
            end
        end
        s_if.validi = 1'b0;
    endtask

    initial begin
        int up, lo, lvl, md;

        rst = 1'b1; start = 1'b0; sec_lvl = 3'd0; mode = 2'd0; npoly = 4'd0;
        s_if.validi = 1'b0; s_if.di = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Exact-bound lanes just outside the band
        ref_bounds(2, 1, up, lo);
        build_safe(up, lo, 64, 0);
        stim[0] = {24'hFFFFFF, 24'd0, 24'd8249424, 24'd130993};
        run_check("bnd_ok", 2, 1, 1, 0, -1, 1'b0);

        // Exact-bound lanes on the band edges, plus a later reject
        stim[5] = {24'd7, 24'd8249423, 24'd3, 24'd130994};
        stim[9] = {24'd130994, 24'd0, 24'd0, 24'd0};
        run_check("bnd_rej", 2, 1, 1, 0, -1, 1'b0);

        // Single lane at UPPER deep in the vector
        for (int i = 0; i < 384; i++) stim[i] = '0;
        stim[4*BEATS + 17][2*COEF_W +: COEF_W] = 24'd261888;
        run_check("lvl3_p4b17", 3, 2, 6, 0, -1, 1'b0);

        // Two rejects, first one wins; start poked mid-run and in the done cycle
        ref_bounds(5, 0, up, lo);
        build_safe(up, lo, 512, 0);
        stim[1*BEATS + 3][$urandom_range(3, 0)*COEF_W +: COEF_W]  = pick_band(up, lo);
        stim[5*BEATS + 60][$urandom_range(3, 0)*COEF_W +: COEF_W] = pick_band(up, lo);
        run_check("lvl5_two", 5, 0, 8, 20, -1, 1'b1);

        // Random config, npoly=0, ~50% validi gaps
        repeat (3) begin
            lvl = rand_lvl();
            md  = int'($urandom_range(3, 0));
            ref_bounds(lvl, md, up, lo);
            build_safe(up, lo, 64, 4);
            run_check("gaps_np0", lvl, md, 0, 50, -1, 1'b0);
        end

        // npoly clamp, mode 3, reject only on the very last beat
        ref_bounds(3, 3, up, lo);
        build_safe(up, lo, 512, 0);
        stim[511][0 +: COEF_W] = 24'd261888;
        run_check("clamp_last", 3, 3, 11, 10, -1, 1'b0);

        // Reset mid-run at beat 30, then a clean check
        ref_bounds(2, 0, up, lo);
        build_safe(up, lo, 128, 0);
        stim[5][COEF_W +: COEF_W] = pick_band(up, lo);
        run_check("abort", 2, 0, 2, 0, 30, 1'b0);
        build_safe(up, lo, 128, 0);
        run_check("after_abort", 2, 0, 2, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
